// File: rtl/seven_segment_capture.sv
// Reads a multiplexed 4-digit seven-segment display and rebuilds the shown value
// as a nibble-per-digit word on an stb/ack stream.
module seven_segment_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EMIT_ON_CHANGE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_select,
    input  logic [6:0]  seven_segment,
    output logic [15:0] out1,
    output logic        out1_stb,
    input  logic        out1_ack,
    output logic        overrun
);

    localparam logic [15:0] SETTLE    = 16'(SETTLE_CYCLES);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_CYCLES - 1);

    typedef enum logic {EMPTY, VALID} state_t;

    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode_seg = 4'h0;
            7'h06:   decode_seg = 4'h1;
            7'h5B:   decode_seg = 4'h2;
            7'h4F:   decode_seg = 4'h3;
            7'h66:   decode_seg = 4'h4;
            7'h6D:   decode_seg = 4'h5;
            7'h7D:   decode_seg = 4'h6;
            7'h07:   decode_seg = 4'h7;
            7'h7F:   decode_seg = 4'h8;
            7'h6F:   decode_seg = 4'h9;
            7'h00:   decode_seg = 4'hA;
            default: decode_seg = 4'hF;
        endcase
    endfunction

    logic [3:0]  sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [10:0] prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  seen_q, seen_d;
    logic        cand_v_q, cand_v_d;
    logic [15:0] cand_q, cand_d;
    state_t      state_q, state_d;
    logic [15:0] out1_q, out1_d;
    logic [15:0] pending_q, pending_d;
    logic        pending_v_q, pending_v_d;
    logic [15:0] last_q, last_d;
    logic        last_v_q, last_v_d;
    logic        overrun_q, overrun_d;

    logic [3:0]  sel_n;
    logic [6:0]  seg_n;
    logic [10:0] sample;
    logic        stable;
    logic        accept;
    logic        offer;
    logic        take;
    logic [3:0]  digit;

    always_comb begin
        sel_s1_d    = digit_select;
        sel_s2_d    = sel_s1_q;
        seg_s1_d    = seven_segment;
        seg_s2_d    = seg_s1_q;
        sel_n       = (SEL_ACTIVE_LOW != 0) ? ~sel_s2_q : sel_s2_q;
        seg_n       = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_q : seg_s2_q;
        sample      = {sel_n, seg_n};
        stable      = (sample == prev_q);
        prev_d      = sample;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        seen_d      = seen_q;
        cand_v_d    = 1'b0;
        cand_d      = cand_q;
        state_d     = state_q;
        out1_d      = out1_q;
        pending_d   = pending_q;
        pending_v_d = pending_v_q;
        last_d      = last_q;
        last_v_d    = last_v_q;
        overrun_d   = 1'b0;
        digit       = decode_seg(seg_n);

        // Settle counter saturates so a long stable run accepts only once.
        if (!stable) begin
            cnt_d = 16'd0;
        end else if (cnt_q != SETTLE) begin
            cnt_d = cnt_q + 16'd1;
        end
        accept = stable && (cnt_q == SETTLE_M1);

        if (seen_q == 4'hF) begin
            cand_v_d = 1'b1;
            cand_d   = frame_q;
            seen_d   = 4'h0;
        end
        if (accept && $onehot(sel_n)) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_n[i]) begin
                    frame_d[4*i +: 4] = digit;
                    seen_d[i]         = 1'b1;
                end
            end
        end

        offer = cand_v_q && !((EMIT_ON_CHANGE != 0) && last_v_q && (cand_q == last_q));
        take  = (state_q == VALID) && out1_ack;
        if (offer) begin
            last_d   = cand_q;
            last_v_d = 1'b1;
        end

        case (state_q)
            EMPTY: begin
                if (offer) begin
                    out1_d  = cand_q;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (take) begin
                    if (pending_v_q) begin
                        out1_d = pending_q;
                        if (offer) begin
                            pending_d = cand_q;
                        end else begin
                            pending_v_d = 1'b0;
                        end
                    end else if (offer) begin
                        out1_d = cand_q;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (offer) begin
                    pending_d   = cand_q;
                    pending_v_d = 1'b1;
                    overrun_d   = pending_v_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_s1_q    <= 4'h0;
            sel_s2_q    <= 4'h0;
            seg_s1_q    <= 7'h00;
            seg_s2_q    <= 7'h00;
            prev_q      <= 11'h000;
            cnt_q       <= 16'd0;
            frame_q     <= 16'h0000;
            seen_q      <= 4'h0;
            cand_v_q    <= 1'b0;
            cand_q      <= 16'h0000;
            state_q     <= EMPTY;
            out1_q      <= 16'h0000;
            pending_q   <= 16'h0000;
            pending_v_q <= 1'b0;
            last_q      <= 16'h0000;
            last_v_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sel_s1_q    <= sel_s1_d;
            sel_s2_q    <= sel_s2_d;
            seg_s1_q    <= seg_s1_d;
            seg_s2_q    <= seg_s2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            seen_q      <= seen_d;
            cand_v_q    <= cand_v_d;
            cand_q      <= cand_d;
            state_q     <= state_d;
            out1_q      <= out1_d;
            pending_q   <= pending_d;
            pending_v_q <= pending_v_d;
            last_q      <= last_d;
            last_v_q    <= last_v_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out1     = out1_q;
    assign out1_stb = (state_q == VALID);
    assign overrun  = overrun_q;

endmodule
